adder_result_collector: RTL and testbench
=========================================

// Module: adder_result_collector
// PURPOSE
//  Downstream consumer of the 128-input adder tree. Captures one 32-bit fp32 summation per rising edge of ExE_finish.
//  Packs NR consecutive results (one per matrix row) into a vector register and presents it to the next stage
//  (e.g. the CG vector update) with a valid/ready handshake. Drops and flags results arriving while the vector is held.
// PARAMETERS
//  NR  128  rows (results) per output vector
//  DW  32   result width (fp32)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  clear       in   1      synchronous flush of index/flags (vector contents kept)
//  ExE_finish  in   1      adder-tree finish level; rising edge = summation valid
//  summation   in   DW     adder-tree result, sampled on the cycle the edge is detected
//  result_vec  out  NR*DW  packed results, row 0 at [NR*DW-1 -: DW], row r at [DW*(NR-r)-1 -: DW]
//  vec_valid   out  1      full vector available
//  vec_ready   in   1      consumer accepts vector when vec_valid & vec_ready
//  row_idx     out  clog2(NR)+1  next row slot to be written (0..NR)
//  overflow    out  1      sticky: a result was dropped
//  exc_flag    out  1      sticky fp exception (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=COLLECT, row_idx=0, vec_valid=0, overflow=0, exc_flag=0, result_vec=0, fin_d=0.
//  Edge detect: fin_d <= ExE_finish each cycle; cap = ExE_finish & ~fin_d. A level held high captures once only.
//  States: COLLECT (vec_valid=0) and HOLD (vec_valid=1).
//  COLLECT: on cap, slot[row_idx] <= summation and row_idx++. Capture of row NR-1 -> HOLD next cycle, row_idx=NR.
//  Latency: vec_valid rises 1 cycle after the clock sampling the NR-th cap.
//  HOLD: result_vec stable. vec_valid & vec_ready -> COLLECT, row_idx=0.
//  HOLD with cap and no handshake: result dropped, overflow <= 1.
//  HOLD with cap and handshake in the same cycle: result written to slot 0, row_idx=1, state COLLECT, no overflow.
//  vec_ready with vec_valid=0: ignored.
//  clear (sync; priority over cap and handshake): row_idx=0, state COLLECT, vec_valid=0, overflow=0, exc_flag=0.
//  clear also sets fin_d <= ExE_finish, so a level already high is not recaptured.
//  Reset mid-vector: partial vector discarded, all regs to reset values.
//  No arithmetic on data: summation stored bit-exact. row_idx never wraps past NR.
// CONFIGURATION
//  FP_EXC_CHECK_EN defined: on each accepted cap, if summation[30:23]==8'hFF (Inf/NaN), exc_flag <= 1.
//    exc_flag is sticky; it clears on vector handshake (same edge as vec_valid falls), on clear, or on reset.
//    If a cap of Inf/NaN coincides with a handshake, exc_flag = 1 afterwards (the new vector owns it).
//  FP_EXC_CHECK_EN undefined: exc_flag tied to 0; port still present; no other behaviour changes.
// STRUCTURE
//  Shared package: DW, NR default, state encoding (COLLECT=1'b0, HOLD=1'b1),
//    fp32 field constants (EXP_MSB=30, EXP_LSB=23), function is_inf_nan(fp32).
//  One sub-module: finish_edge_detect (clk, rst_n, clear, level_in, pulse_out), reused by other stages in the chain.
//  Slot registers: generate loop of NR DW-bit regs, write-enabled by cap & (row_idx==i) & ~HOLD-drop.
// TESTING
//  1. NR=4, four finish edges with sums 3F800000,40000000,40400000,40800000 -> result_vec={3F80..,4000..,4040..,4080..},
//     vec_valid=1 one cycle after the 4th capture.
//  2. ExE_finish held high 10 cycles -> exactly one capture, row_idx 0->1.
//  3. NR=4 vector held, vec_ready=0, 5th edge -> overflow=1, result_vec unchanged; vec_ready=1 -> row_idx=0.
//  4. HOLD with cap and vec_ready the same cycle, sum 41200000 -> slot0=41200000, row_idx=1, overflow=0.
//  5. rst_n low after 2 captures -> all outputs 0 asynchronously; clear with ExE_finish high -> no spurious capture.
//  6. FP_EXC_CHECK_EN: capture 7F800000 -> exc_flag=1, cleared on handshake; macro undefined -> exc_flag stays 0.

Source files
------------

// File: rtl/adder_result_collector_pkg.sv
// Shared definitions for the adder-tree result collector and neighbouring stages.
package adder_result_collector_pkg;

    // fp32 result width and default row count
    localparam int unsigned FP32_W     = 32;
    localparam int unsigned DW         = FP32_W;
    localparam int unsigned NR_DEFAULT = 128;

    // fp32 exponent field position
    localparam int unsigned EXP_MSB = 30;
    localparam int unsigned EXP_LSB = 23;

    // Collector state encoding
    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // True when the fp32 exponent is all ones (Inf or NaN)
    function automatic logic is_inf_nan(input logic [FP32_W-1:0] v);
        return &v[EXP_MSB:EXP_LSB];
    endfunction

endpackage

// File: rtl/adder_result_collector_finish_edge_detect.sv
// Rising-edge detector for the adder-tree finish level; one pulse per level assertion.
module finish_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic level_in,
    output logic pulse_out
);

    logic fin_d;

    // Delayed copy of the level; a flush also re-arms it to the current level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_d <= 1'b0;
        end else begin
            fin_d <= level_in;
        end
    end

    // Pulse on 0->1 transition, suppressed during a flush
    assign pulse_out = level_in & ~fin_d & ~clear;

endmodule

// File: rtl/adder_result_collector.sv
// Packs NR consecutive adder-tree results into one vector with valid/ready handoff.
// Optional build macro FP_EXC_CHECK_EN enables the sticky Inf/NaN exception flag.
module adder_result_collector #(
    parameter int unsigned NR = adder_result_collector_pkg::NR_DEFAULT,
    parameter int unsigned DW = adder_result_collector_pkg::DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     ExE_finish,
    input  logic [DW-1:0]            summation,
    output logic [NR*DW-1:0]         result_vec,
    output logic                     vec_valid,
    input  logic                     vec_ready,
    output logic [$clog2(NR):0]      row_idx,
    output logic                     overflow,
    output logic                     exc_flag
);

    import adder_result_collector_pkg::*;

    localparam int unsigned IW = $clog2(NR) + 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   row_idx_q, row_idx_d;
    logic            overflow_q, overflow_d;
    logic            exc_q, exc_d;
    logic            cap;
    logic            cap_exc;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;

    // Finish-level edge detection
    finish_edge_detect u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .level_in  (ExE_finish),
        .pulse_out (cap)
    );

    // Inf/NaN classification of the incoming result
`ifdef FP_EXC_CHECK_EN
    assign cap_exc = is_inf_nan(summation);
`else
    assign cap_exc = 1'b0;
`endif

    // State, row index and sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            row_idx_q  <= '0;
            overflow_q <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            overflow_q <= overflow_d;
            exc_q      <= exc_d;
        end
    end

    // Next-state, slot write selection and flag updates
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        overflow_d = overflow_q;
        exc_d      = exc_q;
        wr_en      = 1'b0;
        wr_idx     = row_idx_q;

        if (clear) begin
            state_d    = COLLECT;
            row_idx_d  = '0;
            overflow_d = 1'b0;
            exc_d      = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (cap) begin
                        wr_en     = 1'b1;
                        row_idx_d = row_idx_q + IW'(1);
                        if (cap_exc) begin
                            exc_d = 1'b1;
                        end
                        if (row_idx_q == IW'(NR - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (vec_ready) begin
                        // Vector handed off; a coincident result starts the next vector
                        state_d   = COLLECT;
                        row_idx_d = '0;
                        exc_d     = 1'b0;
                        if (cap) begin
                            wr_en     = 1'b1;
                            wr_idx    = '0;
                            row_idx_d = IW'(1);
                            exc_d     = cap_exc;
                        end
                    end else if (cap) begin
                        overflow_d = 1'b1;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // Per-row result slots, row 0 in the most significant word
    for (genvar i = 0; i < int'(NR); i++) begin : g_slot
        logic [DW-1:0] slot_q;

        // Capture the result into this row when it is the selected slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_q <= '0;
            end else if (wr_en && (wr_idx == IW'(i))) begin
                slot_q <= summation;
            end
        end

        assign result_vec[DW*(int'(NR)-i)-1 -: DW] = slot_q;
    end

    assign vec_valid = (state_q == HOLD);
    assign row_idx   = row_idx_q;
    assign overflow  = overflow_q;
    assign exc_flag  = exc_q;

endmodule

// File: tb/tb_adder_result_collector.sv
// Randomized and directed checks of adder_result_collector (NR=4) against a queue/array model.
module tb_adder_result_collector;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              ExE_finish;
    logic [DW-1:0]     summation;
    logic [NR*DW-1:0]  result_vec;
    logic              vec_valid;
    logic              vec_ready;
    logic [2:0]        row_idx;
    logic              overflow;
    logic              exc_flag;

    int total;
    int bad;

    // behavioural model state
    logic [31:0] mv [NR];
    int          m_cnt;
    bit          m_full;
    bit          m_ovf;
    bit          m_exc;
    bit          m_fin_prev;

    logic [NR*DW+5:0] obs;

    adder_result_collector #(.NR(NR), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .ExE_finish (ExE_finish),
        .summation  (summation),
        .result_vec (result_vec),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .row_idx    (row_idx),
        .overflow   (overflow),
        .exc_flag   (exc_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {result_vec, vec_valid, row_idx, overflow, exc_flag};

    function automatic bit m_is_exc(input logic [31:0] s);
`ifdef FP_EXC_CHECK_EN
        return (s[30:23] == 8'hFF);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [NR*DW+5:0] expected();
        return {mv[0], mv[1], mv[2], mv[3], m_full, 3'(m_cnt), m_ovf, m_exc};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mv[i] = 32'h0;
        m_cnt = 0; m_full = 0; m_ovf = 0; m_exc = 0; m_fin_prev = 0;
    endtask

    // drive one clock cycle of inputs and advance the model at the sampling edge
    task automatic cycle(input logic f, input logic [31:0] s, input logic r, input logic c);
        bit cap;
        ExE_finish = f; summation = s; vec_ready = r; clear = c;
        @(posedge clk);
        cap = f && !m_fin_prev;
        m_fin_prev = f;
        if (c) begin
            m_cnt = 0; m_full = 0; m_ovf = 0; m_exc = 0;
        end else if (m_full) begin
            if (r) begin
                m_full = 0; m_cnt = 0; m_exc = 0;
                if (cap) begin
                    mv[0] = s; m_cnt = 1; m_exc = m_is_exc(s);
                end
            end else if (cap) begin
                m_ovf = 1;
            end
        end else if (cap) begin
            mv[m_cnt] = s;
            m_cnt++;
            if (m_is_exc(s)) m_exc = 1;
            if (m_cnt == NR) m_full = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 0; ExE_finish = 0; summation = '0; vec_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== expected()) begin
            bad++;
            $display("FAIL reset got=%h want=%h", obs, expected());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] sums [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, sums[k], 1'b0, 1'b0);
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("FAIL fill_cap%0d got=%h want=%h", k, obs, expected());
            end
            if (k < 3) begin
                total++;
                if (vec_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_early_valid%0d got=%b want=0", k, vec_valid);
                end
            end
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
        end
        total++;
        if (result_vec !== 128'h3F800000_40000000_40400000_40800000 || vec_valid !== 1'b1
            || row_idx !== 3'd4) begin
            bad++;
            $display("FAIL fill_vector got=%h/%b/%0d want=3f800000400000004040000040800000/1/4",
                     result_vec, vec_valid, row_idx);
        end
    endtask

    task automatic test_overflow();
        logic [NR*DW-1:0] held;
        held = result_vec;
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b1 || result_vec !== held || vec_valid !== 1'b1) begin
            bad++;
            $display("FAIL overflow_drop got=%b/%h want=1/%h", overflow, result_vec, held);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (obs !== expected() || row_idx !== 3'd0 || vec_valid !== 1'b0) begin
            bad++;
            $display("FAIL overflow_handshake got=%h want=%h", obs, expected());
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        total++;
        if (obs !== expected() || overflow !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear got=%h want=%h", obs, expected());
        end
    endtask

    task automatic test_level_held();
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'h1000_0000 + 32'(k), 1'b0, 1'b0);
            total++;
            if (obs !== expected() || row_idx !== 3'd1) begin
                bad++;
                $display("FAIL level_held_%0d got=%h want=%h", k, obs, expected());
            end
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h4100_0000 + 32'(k), 1'b0, 1'b0);
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
        end
        total++;
        if (obs !== expected() || vec_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_full got=%h want=%h", obs, expected());
        end
        cycle(1'b1, 32'h41200000, 1'b1, 1'b0);
        total++;
        if (result_vec[127:96] !== 32'h41200000 || row_idx !== 3'd1 || overflow !== 1'b0
            || vec_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cap_handshake got=%h/%0d/%b/%b want=41200000/1/0/0",
                     result_vec[127:96], row_idx, overflow, vec_valid);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs !== expected()) begin
            bad++;
            $display("FAIL b2b_after got=%h want=%h", obs, expected());
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 32'h5000_0000 + 32'(k), 1'b0, 1'b0);
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", obs);
        end
        #1 rst_n = 1'b1;
        cycle(1'b1, 32'h6000_0000, 1'b0, 1'b1);
        total++;
        if (obs !== expected() || row_idx !== 3'd0) begin
            bad++;
            $display("FAIL clear_level got=%h want=%h", obs, expected());
        end
        cycle(1'b1, 32'h6000_0001, 1'b0, 1'b0);
        total++;
        if (obs !== expected() || row_idx !== 3'd0) begin
            bad++;
            $display("FAIL clear_no_recap got=%h want=%h", obs, expected());
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_exc();
        bit want;
`ifdef FP_EXC_CHECK_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h7F800000, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        total++;
        if (exc_flag !== want || obs !== expected()) begin
            bad++;
            $display("FAIL exc_set got=%b want=%b", exc_flag, want);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h3F00_0000 + 32'(k), 1'b0, 1'b0);
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
        end
        total++;
        if (exc_flag !== want || vec_valid !== 1'b1) begin
            bad++;
            $display("FAIL exc_held got=%b/%b want=%b/1", exc_flag, vec_valid, want);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (exc_flag !== 1'b0 || obs !== expected()) begin
            bad++;
            $display("FAIL exc_handshake got=%b want=0", exc_flag);
        end
    endtask

    task automatic test_random();
        logic        f;
        logic [31:0] s;
        for (int k = 0; k < 400; k++) begin
            f = ($urandom_range(0, 2) != 0) ? ~ExE_finish : ExE_finish;
            s = $urandom;
            if ($urandom_range(0, 5) == 0) s[30:23] = 8'hFF;
            cycle(f, s, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0));
            total++;
            if (obs !== expected()) begin
                bad++;
                $display("FAIL random_%0d got=%h want=%h", k, obs, expected());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_level_held();
        test_back_to_back();
        test_reset_mid();
        test_exc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
